quick_spi_slave: RTL and testbench
==================================

Name: quick_spi_slave

Overview:
SPI responder (slave) for the far end of the quick_spi master link. It oversamples sclk, ss_n and mosi in the local clk domain and assembles received words. It shifts tx words out on miso and hands words to and from local logic through a valid/ack handshake. It serves as the loopback partner in quick_spi system benches and as synthesizable peripheral-side logic.

Parameters:
DATA_WIDTH, 8, bits per word; shift register and counter width.
CPOL, 0, sclk idle level.
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
LSB_FIRST, 1, 1 = bit 0 shifted first on both mosi and miso.
SYNC_STAGES, 2, flip-flops per input synchronizer (minimum 2).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset.
sclk  in  1  SPI clock from master, asynchronous.
ss_n  in  1  slave select from master, active-low, asynchronous.
mosi  in  1  master-out data, asynchronous.
miso  out  1  slave-out data.
miso_oe  out  1  high while selected; drives external tristate.
tx_data  in  DATA_WIDTH  next word to transmit.
tx_valid  in  1  tx_data holds a word.
tx_ack  out  1  one-cycle pulse: tx_data was captured.
tx_underrun  out  1  one-cycle pulse: load point reached with tx_valid low.
rx_data  out  DATA_WIDTH  last complete received word; held until the next word completes.
rx_valid  out  1  one-cycle pulse when rx_data updates.
busy  out  1  high in ACTIVE state.
end_of_transaction  out  1  one-cycle pulse on synchronized ss_n rising edge.
frame_error  out  1  one-cycle pulse when ss_n rises with bit_cnt != 0.

Behaviour:
- Reset is synchronous, active-low: rst_n, sampled on clk rising edge. Clock is clk.
- Reset values: all outputs 0, rx_data 0, shift registers 0, bit_cnt 0, state WAIT_IDLE.
- Inputs pass through SYNC_STAGES flops. sclk edges are detected on the synchronized signal (previous vs current stage). Decisions use synchronized values only.
- Timing constraint: sclk high and low times are each >= SYNC_STAGES+2 clk periods. ss_n setup and hold around the first and last sclk edges are each >= SYNC_STAGES+2 clk periods.
- Sample edge: leading edge when CPHA=0, trailing when CPHA=1. Shift edge is the opposite edge. Leading edge = rising when CPOL=0, falling when CPOL=1.
- States:
  - WAIT_IDLE: entered after reset. Go to IDLE once synced ss_n is 1. A frame already in progress at reset release is ignored.
  - IDLE: on synced ss_n falling edge, load the tx shift register (see load point), set bit_cnt=0, go to ACTIVE.
  - ACTIVE: on each sample edge, shift synced mosi into the rx shifter (LSB_FIRST selects the shift direction) and increment bit_cnt.
    - When bit_cnt reaches DATA_WIDTH-1 and a sample occurs: rx_data <= completed word, rx_valid pulses the next cycle, bit_cnt wraps to 0.
    - On each shift edge, advance miso to the next tx bit, except the first shift edge when CPHA=1.
    - A word boundary (bit_cnt wrap) with CPHA=0, or the next leading edge with CPHA=1, is a load point. This supports back-to-back words with no gap.
    - Synced ss_n rising edge: pulse end_of_transaction and go to IDLE. Also pulse frame_error if bit_cnt != 0; the partial word is discarded and rx_data is unchanged.
- Load point:
  - If tx_valid=1: capture tx_data and pulse tx_ack in the same cycle.
  - If tx_valid=0: load all zeros and pulse tx_underrun.
- With CPHA=0, the first tx bit is on miso by the cycle after the ss_n falling edge is detected.
- miso_oe = busy. When miso_oe=0, miso=0.
- Simultaneous events:
  - ss_n rising edge in the same cycle as a sample edge: the sample is dropped; ss_n takes priority.
  - Word completion and ss_n rise in the same cycle: rx_valid still pulses.
- Latency: rx_valid asserts SYNC_STAGES+2 clk cycles after the final sample sclk edge at the pin.

Decomposition:
- Package quick_spi_pkg: state enum (WAIT_IDLE, IDLE, ACTIVE); CPOL/CPHA mode constants shared with the master.
- Sub-module spi_input_sync: SYNC_STAGES synchronizer for sclk, ss_n and mosi. Outputs the synced levels plus sclk_rise, sclk_fall and ss_fall/ss_rise pulses.

Test Plan:
- Mode 0, LSB first, tx_data=0x95, tx_valid=1; master sends 0x6A -> rx_data=0x6A with one rx_valid pulse; master captures 0x95; one tx_ack; end_of_transaction pulses once.
- Mode 3 (CPOL=1, CPHA=1), MSB first; master sends 0x1A then 0x6A back-to-back in one frame; tx_data 0xC3 then 0x3C -> two rx_valid pulses with 0x1A and 0x6A; master receives 0xC3 and 0x3C; two tx_ack pulses.
- tx_valid=0 during a frame -> tx_underrun pulses at the load point; master receives 0x00; rx path is unaffected.
- ss_n released after 5 bits -> frame_error and end_of_transaction pulse; no rx_valid; rx_data keeps its prior value; the next full frame with 0xA5 receives correctly.
- rst_n asserted for 3 cycles at bit 4 with ss_n held low -> outputs reset to 0; remainder of that frame ignored (no rx_valid); next frame with 0x5A receives correctly.
- Idle checks: miso=0 and miso_oe=0 whenever ss_n=1; sclk toggling with ss_n=1 produces no rx_valid.

Source files
------------

// File: rtl/quick_spi_pkg.sv
// Shared types and SPI mode constants for the quick_spi master/slave pair.
// Mode numbering follows the usual {CPOL, CPHA} convention.
package quick_spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int MIN_SYNC_STAGES = 2;

  // Data is sampled on the rising sclk edge in modes 0 and 3, falling in 1 and 2.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    logic rise;
    case (mode)
      SPI_MODE0, SPI_MODE3: rise = 1'b1;
      SPI_MODE1, SPI_MODE2: rise = 1'b0;
      default:              rise = 1'b1;
    endcase
    return rise;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for the asynchronous SPI pins, with edge detection
// performed on the synchronized sclk and ss_n levels.
module spi_input_sync
  import quick_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic ss_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_rise,
  output logic ss_fall
);

  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sclk_q;
  logic [STAGES-1:0] ss_q;
  logic [STAGES-1:0] mosi_q;
  logic              sclk_d;
  logic              ss_d;

  // NOTE: non-blocking assignments let every stage take the previous stage's old value, forming a true shift chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      ss_d   <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[STAGES-2:0], sclk};
      ss_q   <= {ss_q[STAGES-2:0], ss_n};
      mosi_q <= {mosi_q[STAGES-2:0], mosi};
      sclk_d <= sclk_q[STAGES-1];
      ss_d   <= ss_q[STAGES-1];
    end
  end

  assign ss_n_s    = ss_q[STAGES-1];
  assign mosi_s    = mosi_q[STAGES-1];
  assign sclk_rise = sclk_q[STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[STAGES-1] & sclk_d;
  assign ss_rise   = ss_q[STAGES-1] & ~ss_d;
  assign ss_fall   = ~ss_q[STAGES-1] & ss_d;

endmodule

// File: rtl/quick_spi_slave.sv
// Oversampling SPI responder: receives words on mosi, returns tx words on miso,
// and exchanges words with local logic through valid/ack pulses.
module quick_spi_slave
  import quick_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ack,
  output logic                  tx_underrun,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  end_of_transaction,
  output logic                  frame_error
);

  localparam int                CNT_W       = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_WIDTH - 1);
  localparam logic [1:0]        MODE        = {CPOL[0], CPHA[0]};
  localparam logic              SAMPLE_RISE = sample_on_rise(MODE);

  logic ss_n_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;

  spi_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .ss_n_s   (ss_n_s),
    .mosi_s   (mosi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .ss_rise  (ss_rise),
    .ss_fall  (ss_fall)
  );

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  rx_done;

  logic                  sample_edge;
  logic                  shift_edge;
  logic                  in_frame;
  logic                  load_now;
  logic                  shift_now;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_advanced;
  logic                  tx_bit;

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

  // A rising ss_n in the same cycle as an sclk edge wins; the edge is ignored.
  assign in_frame = (state == ACTIVE) && !ss_rise;

  // NOTE: every always_comb output gets a default first so no path can hold a value and infer a latch.
  always_comb begin
    load_now    = 1'b0;
    shift_now   = 1'b0;
    rx_next     = rx_shift;
    tx_advanced = tx_shift;
    if (CPHA == 0) begin
      load_now  = ((state == IDLE) && ss_fall) ||
                  (in_frame && sample_edge && (bit_cnt == LAST_BIT));
    end else begin
      load_now  = in_frame && shift_edge && (bit_cnt == '0);
    end
    // bit_cnt==0 on a shift edge means a fresh word: loaded, not advanced.
    shift_now = in_frame && shift_edge && (bit_cnt != '0);
    if (LSB_FIRST != 0) begin
      rx_next     = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
      tx_advanced = {1'b0, tx_shift[DATA_WIDTH-1:1]};
    end else begin
      rx_next     = {rx_shift[DATA_WIDTH-2:0], mosi_s};
      tx_advanced = {tx_shift[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign tx_bit  = (LSB_FIRST != 0) ? tx_shift[0] : tx_shift[DATA_WIDTH-1];
  assign busy    = (state == ACTIVE);
  assign miso_oe = busy;
  assign miso    = busy & tx_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= WAIT_IDLE;
      bit_cnt            <= '0;
      rx_shift           <= '0;
      tx_shift           <= '0;
      rx_done            <= 1'b0;
      rx_data            <= '0;
      rx_valid           <= 1'b0;
      tx_ack             <= 1'b0;
      tx_underrun        <= 1'b0;
      end_of_transaction <= 1'b0;
      frame_error        <= 1'b0;
    end else begin
      rx_valid           <= rx_done;
      rx_done            <= 1'b0;
      tx_ack             <= 1'b0;
      tx_underrun        <= 1'b0;
      end_of_transaction <= 1'b0;
      frame_error        <= 1'b0;

      if (load_now) begin
        tx_shift    <= tx_valid ? tx_data : '0;
        tx_ack      <= tx_valid;
        tx_underrun <= !tx_valid;
      end else if (shift_now) begin
        tx_shift    <= tx_advanced;
      end

      case (state)
        WAIT_IDLE: begin
          if (ss_n_s) state <= IDLE;
        end
        IDLE: begin
          if (ss_fall) begin
            state   <= ACTIVE;
            bit_cnt <= '0;
            // With CPHA=1 the first word is loaded on the first leading edge.
            if (CPHA != 0) tx_shift <= '0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state              <= IDLE;
            end_of_transaction <= 1'b1;
            frame_error        <= (bit_cnt != '0);
            bit_cnt            <= '0;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              rx_data <= rx_next;
              rx_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi_slave.sv
// Bench for quick_spi_slave: one mode-0 LSB-first and one mode-3 MSB-first
// instance, each driven by a bit-banged master model.
module tb_quick_spi_slave;

  localparam int CLK_T = 10;
  localparam int H     = 6;
  localparam int NV    = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk[2];
  logic       ss_n[2];
  logic       mosi[2];
  logic       miso[2];
  logic       miso_oe[2];
  logic [7:0] tx_data[2];
  logic       tx_valid[2];
  logic       tx_ack[2];
  logic       tx_underrun[2];
  logic [7:0] rx_data[2];
  logic       rx_valid[2];
  logic       busy[2];
  logic       eot[2];
  logic       ferr[2];

  int total = 0;
  int bad   = 0;

  int         rxv_cnt[2]  = '{0, 0};
  int         ack_cnt[2]  = '{0, 0};
  int         und_cnt[2]  = '{0, 0};
  int         eot_cnt[2]  = '{0, 0};
  int         ferr_cnt[2] = '{0, 0};
  time        rxv_t[2]    = '{0, 0};
  logic [7:0] rx_hist[2][64];

  int         ack_base[2] = '{0, 0};
  int         tx_n[2]     = '{0, 0};
  logic [7:0] txw[2][2];
  time        last_sample_t = 0;

  always #(CLK_T/2) clk = ~clk;

  // Local-logic stand-in: offers txw words in order, advancing on each tx_ack.
  assign tx_valid[0] = (ack_cnt[0] - ack_base[0]) < tx_n[0];
  assign tx_valid[1] = (ack_cnt[1] - ack_base[1]) < tx_n[1];
  assign tx_data[0]  = txw[0][(ack_cnt[0] - ack_base[0]) & 1];
  assign tx_data[1]  = txw[1][(ack_cnt[1] - ack_base[1]) & 1];

  quick_spi_slave #(
    .DATA_WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(1), .SYNC_STAGES(2)
  ) u_mode0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[0]), .ss_n(ss_n[0]), .mosi(mosi[0]),
    .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ack(tx_ack[0]), .tx_underrun(tx_underrun[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .busy(busy[0]), .end_of_transaction(eot[0]),
    .frame_error(ferr[0])
  );

  quick_spi_slave #(
    .DATA_WIDTH(8), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .SYNC_STAGES(2)
  ) u_mode3 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[1]), .ss_n(ss_n[1]), .mosi(mosi[1]),
    .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ack(tx_ack[1]), .tx_underrun(tx_underrun[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .busy(busy[1]), .end_of_transaction(eot[1]),
    .frame_error(ferr[1])
  );

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rx_valid[d]) begin
        rx_hist[d][rxv_cnt[d] & 63] <= rx_data[d];
        rxv_cnt[d]                  <= rxv_cnt[d] + 1;
        rxv_t[d]                    <= $time;
      end
      if (tx_ack[d])      ack_cnt[d]  <= ack_cnt[d] + 1;
      if (tx_underrun[d]) und_cnt[d]  <= und_cnt[d] + 1;
      if (eot[d])         eot_cnt[d]  <= eot_cnt[d] + 1;
      if (ferr[d])        ferr_cnt[d] <= ferr_cnt[d] + 1;
    end
  end

  typedef struct {
    int rxv, ack, und, eot, ferr;
  } snap_t;

  typedef struct {
    int         dut;
    int         nw;
    logic [7:0] mo0, mo1;
    logic [7:0] tx0, tx1;
    int         ntx;
    logic [7:0] exp_mi0, exp_mi1;
    int         exp_ack;
    int         exp_und;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic snap_t take(input int d);
    snap_t s;
    s.rxv  = rxv_cnt[d];
    s.ack  = ack_cnt[d];
    s.und  = und_cnt[d];
    s.eot  = eot_cnt[d];
    s.ferr = ferr_cnt[d];
    return s;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Instance 0 is mode 0 (idle low, sample on rise); instance 1 is mode 3.
  task automatic drive_bit(input int d, input logic b, output logic m);
    logic lead;
    lead = (d == 0) ? 1'b1 : 1'b0;
    if (d == 0) begin
      mosi[d] = b;
      wait_cyc(H);
      m = miso[d];
      sclk[d] = lead;
      last_sample_t = $time;
      wait_cyc(H);
      sclk[d] = ~lead;
    end else begin
      sclk[d] = lead;
      mosi[d] = b;
      wait_cyc(H);
      m = miso[d];
      sclk[d] = ~lead;
      last_sample_t = $time;
      wait_cyc(H);
    end
  endtask

  task automatic drive_word(input int d, input logic [7:0] w, input int first, input int nbits,
                            inout logic [7:0] got);
    for (int i = first; i < first + nbits; i++) begin
      int   bi;
      logic m;
      bi = (d == 0) ? i : 7 - i;
      drive_bit(d, w[bi], m);
      got[bi] = m;
    end
  endtask

  task automatic ss_low(input int d);
    ss_n[d] = 1'b0;
    wait_cyc(H);
  endtask

  task automatic ss_high(input int d);
    wait_cyc(H);
    ss_n[d] = 1'b1;
    wait_cyc(2 * H);
  endtask

  task automatic frame(input int d, input int nw, input logic [7:0] w0, input logic [7:0] w1,
                       output logic [7:0] g0, output logic [7:0] g1);
    g0 = 8'h00;
    g1 = 8'h00;
    ss_low(d);
    drive_word(d, w0, 0, 8, g0);
    if (nw > 1) drive_word(d, w1, 0, 8, g1);
    ss_high(d);
  endtask

  vec_t       vecs[NV];
  logic [7:0] last_rx[2];

  initial begin
    vec_t       t;
    snap_t      s;
    logic [7:0] g0, g1;
    int         d;

    vecs[0] = '{dut: 0, nw: 1, mo0: 8'h6A, mo1: 8'h00, tx0: 8'h95, tx1: 8'h00, ntx: 1,
                exp_mi0: 8'h95, exp_mi1: 8'h00, exp_ack: 1, exp_und: 1};
    vecs[1] = '{dut: 1, nw: 2, mo0: 8'h1A, mo1: 8'h6A, tx0: 8'hC3, tx1: 8'h3C, ntx: 2,
                exp_mi0: 8'hC3, exp_mi1: 8'h3C, exp_ack: 2, exp_und: 0};
    vecs[2] = '{dut: 0, nw: 2, mo0: 8'h12, mo1: 8'h34, tx0: 8'hAB, tx1: 8'hCD, ntx: 2,
                exp_mi0: 8'hAB, exp_mi1: 8'hCD, exp_ack: 2, exp_und: 1};
    vecs[3] = '{dut: 0, nw: 1, mo0: 8'h3C, mo1: 8'h00, tx0: 8'hFF, tx1: 8'h00, ntx: 0,
                exp_mi0: 8'h00, exp_mi1: 8'h00, exp_ack: 0, exp_und: 2};
    vecs[4] = '{dut: 1, nw: 1, mo0: 8'h81, mo1: 8'h00, tx0: 8'hFF, tx1: 8'h00, ntx: 0,
                exp_mi0: 8'h00, exp_mi1: 8'h00, exp_ack: 0, exp_und: 1};

    sclk[0] = 1'b0; sclk[1] = 1'b1;
    ss_n[0] = 1'b1; ss_n[1] = 1'b1;
    mosi[0] = 1'b0; mosi[1] = 1'b0;
    txw[0][0] = 8'h00; txw[0][1] = 8'h00; txw[1][0] = 8'h00; txw[1][1] = 8'h00;
    last_rx[0] = 8'h00; last_rx[1] = 8'h00;
    rst_n = 1'b0;
    wait_cyc(5);

    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset%0d rx_data", k), rx_data[k], 8'h00);
      check($sformatf("reset%0d flags", k),
            {rx_valid[k], busy[k], miso_oe[k], miso[k], tx_ack[k], tx_underrun[k], eot[k], ferr[k]},
            8'h00);
    end
    rst_n = 1'b1;
    wait_cyc(10);

    for (int v = 0; v < NV; v++) begin
      t = vecs[v];
      d = t.dut;
      txw[d][0]   = t.tx0;
      txw[d][1]   = t.tx1;
      ack_base[d] = ack_cnt[d];
      tx_n[d]     = t.ntx;
      s = take(d);
      frame(d, t.nw, t.mo0, t.mo1, g0, g1);
      tx_n[d] = 0;
      check($sformatf("v%0d rx_valid count", v), rxv_cnt[d] - s.rxv, t.nw);
      check($sformatf("v%0d rx word0", v), rx_hist[d][s.rxv & 63], t.mo0);
      check($sformatf("v%0d miso word0", v), g0, t.exp_mi0);
      if (t.nw > 1) begin
        check($sformatf("v%0d rx word1", v), rx_hist[d][(s.rxv + 1) & 63], t.mo1);
        check($sformatf("v%0d miso word1", v), g1, t.exp_mi1);
      end
      last_rx[d] = (t.nw > 1) ? t.mo1 : t.mo0;
      check($sformatf("v%0d rx_data held", v), rx_data[d], last_rx[d]);
      check($sformatf("v%0d tx_ack count", v), ack_cnt[d] - s.ack, t.exp_ack);
      check($sformatf("v%0d tx_underrun count", v), und_cnt[d] - s.und, t.exp_und);
      check($sformatf("v%0d eot count", v), eot_cnt[d] - s.eot, 1);
      check($sformatf("v%0d frame_error count", v), ferr_cnt[d] - s.ferr, 0);
      check($sformatf("v%0d rx latency", v), 32'(rxv_t[d] - last_sample_t), 32'(4 * CLK_T));
      check($sformatf("v%0d idle miso/oe", v), {miso[d], miso_oe[d]}, 2'b00);
    end

    // Frame cut after 5 bits: error reported, partial word dropped.
    s = take(0);
    g0 = 8'h00;
    ss_low(0);
    drive_word(0, 8'hFF, 0, 5, g0);
    ss_high(0);
    check("cut frame_error", ferr_cnt[0] - s.ferr, 1);
    check("cut eot", eot_cnt[0] - s.eot, 1);
    check("cut rx_valid", rxv_cnt[0] - s.rxv, 0);
    check("cut rx_data kept", rx_data[0], last_rx[0]);
    s = take(0);
    frame(0, 1, 8'hA5, 8'h00, g0, g1);
    check("after cut rx_valid", rxv_cnt[0] - s.rxv, 1);
    check("after cut rx_data", rx_data[0], 8'hA5);
    check("after cut frame_error", ferr_cnt[0] - s.ferr, 0);

    // Reset in mid-frame with ss_n held low: rest of that frame ignored.
    g0 = 8'h00;
    ss_low(0);
    drive_word(0, 8'h0F, 0, 4, g0);
    rst_n = 1'b0;
    wait_cyc(3);
    check("midreset rx_data", rx_data[0], 8'h00);
    check("midreset flags", {rx_valid[0], busy[0], miso_oe[0], miso[0]}, 4'h0);
    check("midreset other rx_data", rx_data[1], 8'h00);
    rst_n = 1'b1;
    s = take(0);
    drive_word(0, 8'h0F, 4, 4, g0);
    check("midreset busy during tail", busy[0], 1'b0);
    ss_high(0);
    check("midreset tail rx_valid", rxv_cnt[0] - s.rxv, 0);
    check("midreset tail rx_data", rx_data[0], 8'h00);
    s = take(0);
    frame(0, 1, 8'h5A, 8'h00, g0, g1);
    check("after reset rx_valid", rxv_cnt[0] - s.rxv, 1);
    check("after reset rx_data", rx_data[0], 8'h5A);

    // sclk activity while deselected must be invisible.
    s = take(0);
    d = rxv_cnt[1];
    for (int i = 0; i < 16; i++) begin
      sclk[0] = ~sclk[0];
      sclk[1] = ~sclk[1];
      mosi[0] = 1'($urandom_range(0, 1));
      mosi[1] = 1'($urandom_range(0, 1));
      wait_cyc(H);
      if (i % 4 == 3) begin
        check($sformatf("idle%0d dut0 miso/oe", i), {miso[0], miso_oe[0]}, 2'b00);
        check($sformatf("idle%0d dut1 miso/oe", i), {miso[1], miso_oe[1]}, 2'b00);
      end
    end
    wait_cyc(2 * H);
    check("idle dut0 rx_valid", rxv_cnt[0] - s.rxv, 0);
    check("idle dut1 rx_valid", rxv_cnt[1] - d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
